// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_cmd_pkg;

    localparam int unsigned OP_W = 4;

    localparam int unsigned BTN_U = 3;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_D = 1;
    localparam int unsigned BTN_R = 0;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_btn_debounce.sv
// One button: 2-flop synchroniser followed by a saturating stable-sample debouncer.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // cnt_q is the length of the current run of equal samples ending in prev_q
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q != prev_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q == CNT_MAX) begin
            level_d = prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Button-chord command sequencer feeding the board ALU; one enable per chord, then a result strobe.
// Build option ALU_CMD_SEQ_SW_OP_EN: op code comes from sw[15:12] and any button acts as "go".
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ALU_LATENCY     = 1,
    parameter int unsigned OPND_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       sw,
    input  logic [3:0]        btn_raw,
    output logic [OP_W-1:0]   op_code,
    output logic [OPND_W-1:0] opnd_a,
    output logic [OPND_W-1:0] opnd_b,
    output logic              alu_enable,
    output logic              result_strobe,
    output logic              busy
);

    localparam logic [3:0] LAT_LAST = 4'(ALU_LATENCY - 1);

    logic [OP_W-1:0]   deb;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   chord_q, chord_d;
    logic              arm_q, arm_d;
    logic [3:0]        lat_q, lat_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [OPND_W-1:0] a_q, a_d;
    logic [OPND_W-1:0] b_q, b_d;

    for (genvar i = 0; i < OP_W; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (btn_raw[i]),
            .level_o(deb[i])
        );
    end

    always_comb begin
        state_d = state_q;
        chord_d = chord_q;
        arm_d   = arm_q;
        lat_d   = lat_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                // arm_q blocks a button still held from the previous command
                if (arm_q && (deb != '0)) begin
                    state_d = COLLECT;
                    chord_d = deb;
                    arm_d   = 1'b0;
                end else if (deb == '0) begin
                    arm_d = 1'b1;
                end
            end
            COLLECT: begin
                chord_d = chord_q | deb;
                if (deb == '0) begin
                    state_d = ISSUE;
`ifdef ALU_CMD_SEQ_SW_OP_EN
                    op_d    = sw[15:12];
                    a_d     = OPND_W'(sw[11:8]);
`else
                    op_d    = chord_q;
                    a_d     = OPND_W'(sw[15:8]);
`endif
                    b_d     = OPND_W'(sw[7:0]);
                end
            end
            ISSUE: begin
                lat_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = DONE;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            DONE: begin
                chord_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            chord_q <= '0;
            arm_q   <= 1'b0;
            lat_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            chord_q <= chord_d;
            arm_q   <= arm_d;
            lat_q   <= lat_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign op_code       = op_q;
    assign opnd_a        = a_q;
    assign opnd_b        = b_q;
    assign alu_enable    = (state_q == ISSUE);
    assign result_strobe = (state_q == DONE);
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: table of single-shot commands plus hand-written corner sequences.
module tb_alu_cmd_sequencer;
    import alu_cmd_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned OW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   sw;
    logic [3:0]    btn_raw;
    logic [3:0]    op_code;
    logic [OW-1:0] opnd_a;
    logic [OW-1:0] opnd_b;
    logic          alu_enable;
    logic          result_strobe;
    logic          busy;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .ALU_LATENCY    (LAT),
        .OPND_W         (OW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .btn_raw      (btn_raw),
        .op_code      (op_code),
        .opnd_a       (opnd_a),
        .opnd_b       (opnd_b),
        .alu_enable   (alu_enable),
        .result_strobe(result_strobe),
        .busy         (busy)
    );

    int unsigned cyc      = 0;
    int unsigned en_cnt   = 0;
    int unsigned st_cnt   = 0;
    int unsigned busy_cnt = 0;
    int unsigned en_cyc   = 0;
    int unsigned st_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (alu_enable === 1'b1) begin
            en_cnt = en_cnt + 1;
            en_cyc = cyc;
        end
        if (result_strobe === 1'b1) begin
            st_cnt = st_cnt + 1;
            st_cyc = cyc;
        end
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strobes(input int unsigned target, input string name);
        int unsigned n = 0;
        while (st_cnt < target && n < 200) begin
            tick();
            n++;
        end
        check({name, "_strobe_seen"}, 32'(st_cnt >= target), 32'd1);
    endtask

    typedef struct {
        logic [15:0] sw;
        logic [3:0]  btn;
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
    } vec_t;

    vec_t vecs[5];

    task automatic run_cmd(input vec_t v, input string name);
        int unsigned e0 = en_cnt;
        int unsigned s0 = st_cnt;
        sw      = v.sw;
        btn_raw = v.btn;
        repeat (20) tick();
        btn_raw = '0;
        wait_strobes(s0 + 1, name);
        check({name, "_enables"}, 32'(en_cnt - e0), 32'd1);
        check({name, "_op"},      32'(op_code), 32'(v.op));
        check({name, "_a"},       32'(opnd_a),  32'(v.a));
        check({name, "_b"},       32'(opnd_b),  32'(v.b));
        check({name, "_latency"}, 32'(st_cyc - en_cyc), 32'(LAT + 1));
        sw = ~v.sw;
        repeat (10) tick();
        check({name, "_hold_op"}, 32'(op_code), 32'(v.op));
        check({name, "_hold_a"},  32'(opnd_a),  32'(v.a));
        check({name, "_hold_b"},  32'(opnd_b),  32'(v.b));
        check({name, "_idle"},    32'({busy, alu_enable, result_strobe}), 32'd0);
        check({name, "_single"},  32'(en_cnt - e0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        int unsigned s0;
        int unsigned b0;
        int unsigned n;

        vecs[0] = '{16'hA53C, 4'b0001, 4'b0001, 8'hA5, 8'h3C};
        vecs[1] = '{16'h1234, 4'b1000, 4'b1000, 8'h12, 8'h34};
        vecs[2] = '{16'hFF00, 4'b0110, 4'b0110, 8'hFF, 8'h00};
        vecs[3] = '{16'h00FF, 4'b1111, 4'b1111, 8'h00, 8'hFF};
        vecs[4] = '{16'h5AA5, 4'b0100, 4'b0100, 8'h5A, 8'hA5};

        reset   = 1'b1;
        sw      = '0;
        btn_raw = '0;
        repeat (3) tick();
        reset = 1'b0;

        // quiet after reset
        repeat (100) tick();
        check("idle_enables", 32'(en_cnt),   32'd0);
        check("idle_strobes", 32'(st_cnt),   32'd0);
        check("idle_busy",    32'(busy_cnt), 32'd0);
        check("idle_outs",    32'({op_code, opnd_a, opnd_b}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // staggered chord: U, then D, U released first, D released last
        e0 = en_cnt;
        s0 = st_cnt;
        sw = 16'hC381;
        btn_raw[BTN_U] = 1'b1;
        repeat (3) tick();
        btn_raw[BTN_D] = 1'b1;
        repeat (12) tick();
        btn_raw[BTN_U] = 1'b0;
        repeat (10) tick();
        btn_raw[BTN_D] = 1'b0;
        wait_strobes(s0 + 1, "chord");
        repeat (20) tick();
        check("chord_op",      32'(op_code), 32'h0000000A);
        check("chord_a",       32'(opnd_a),  32'h000000C3);
        check("chord_b",       32'(opnd_b),  32'h00000081);
        check("chord_enables", 32'(en_cnt - e0), 32'd1);

        // bounce never settles high
        e0 = en_cnt;
        b0 = busy_cnt;
        for (int i = 0; i < 15; i++) begin
            btn_raw[BTN_R] = ~btn_raw[BTN_R];
            repeat (2) tick();
        end
        btn_raw = '0;
        repeat (30) tick();
        check("bounce_enables", 32'(en_cnt - e0), 32'd0);
        check("bounce_busy",    32'(busy_cnt - b0), 32'd0);

        // BTN_L pressed right after BTN_R release and held through WAIT/DONE
        e0 = en_cnt;
        s0 = st_cnt;
        sw = 16'h0102;
        btn_raw[BTN_R] = 1'b1;
        repeat (20) tick();
        btn_raw[BTN_R] = 1'b0;
        tick();
        btn_raw[BTN_L] = 1'b1;
        wait_strobes(s0 + 1, "hold");
        repeat (40) tick();
        check("hold_op",        32'(op_code), 32'd1);
        check("hold_enables",   32'(en_cnt - e0), 32'd1);
        btn_raw[BTN_L] = 1'b0;
        repeat (30) tick();
        check("hold_release",   32'(en_cnt - e0), 32'd1);
        btn_raw[BTN_D] = 1'b1;
        repeat (20) tick();
        btn_raw[BTN_D] = 1'b0;
        wait_strobes(s0 + 2, "hold_repress");
        check("hold_repress_en", 32'(en_cnt - e0), 32'd2);
        check("hold_repress_op", 32'(op_code), 32'd2);
        repeat (10) tick();

        // reset while in WAIT
        e0 = en_cnt;
        s0 = st_cnt;
        sw = 16'h7E81;
        btn_raw[BTN_U] = 1'b1;
        repeat (20) tick();
        btn_raw[BTN_U] = 1'b0;
        n = 0;
        while (en_cnt == e0 && n < 200) begin
            tick();
            n++;
        end
        check("rst_enable_seen", 32'(en_cnt - e0), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("rst_outs", 32'({op_code, opnd_a, opnd_b}), 32'd0);
        check("rst_ctl",  32'({busy, alu_enable, result_strobe}), 32'd0);
        reset = 1'b0;
        repeat (30) tick();
        check("rst_no_strobe", 32'(st_cnt - s0), 32'd0);
        check("rst_idle",      32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
